// File: rtl/arq_pkg.sv
// Shared ARQ definitions: scheduler state encoding and default timing/retry
// constants, also used by the receiver-side ACK generator.
package arq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_ACK = 3'd2,
    RETRANS  = 3'd3,
    FLUSH    = 3'd4
  } arq_state_e;

  localparam int unsigned DEF_TIMEOUT_CYC = 200000;
  localparam int unsigned DEF_MAX_RETRY   = 3;
  localparam int unsigned DEF_TMR_W       = 18;
  localparam int unsigned DEF_RTY_W       = 2;

endpackage

// File: rtl/arq_timeout_timer.sv
// ACK timeout timer: saturating up-counter with clear/enable; o_expire is
// high while the count equals TIMEOUT_CYC-1.
module arq_timeout_timer
  import arq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned TMR_W       = DEF_TMR_W
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expire = (cnt_q == TMR_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/arq_scheduler.sv
// Sender-side ARQ scheduler: selects mapper vs line-FIFO replay, times out
// ACKs, counts retries and pulses the line-FIFO flush. Optional statistics
// counters are enabled with `define ARQ_SCHED_STATS_EN.
module arq_scheduler
  import arq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned MAX_RETRY   = DEF_MAX_RETRY,
  parameter int unsigned TMR_W       = DEF_TMR_W,
  parameter int unsigned RTY_W       = DEF_RTY_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_arq_en,
  input  logic             i_frame_fas,
  input  logic             i_frame_done,
  input  logic             i_ack_valid,
  input  logic             i_ack_good,
  output logic             o_mapper_hold,
  output logic             o_sel_line_fifo,
  output logic             o_retrans_req,
  output logic             o_send_complete,
  output logic             o_fail,
  output logic [RTY_W-1:0] o_retry_cnt
`ifdef ARQ_SCHED_STATS_EN
  ,
  output logic [15:0]      o_tx_frames,
  output logic [15:0]      o_retrans_total,
  output logic [7:0]       o_fail_total
`endif
);

  arq_state_e       state_q, state_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             fail_q, fail_d;
  logic             hold_q, sel_q, req_q, cmpl_q;
  logic             tmr_clr, tmr_en, tmr_expire;

  arq_timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TMR_W       (TMR_W)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (tmr_clr),
    .i_en     (tmr_en),
    .o_expire (tmr_expire)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    fail_d  = fail_q;
    tmr_clr = 1'b0;
    tmr_en  = (state_q == WAIT_ACK);
    unique case (state_q)
      IDLE: begin
        if (i_frame_fas) begin
          state_d = SEND;
          retry_d = '0;
          fail_d  = 1'b0;
        end
      end
      SEND: begin
        if (i_frame_done) begin
          if (!i_arq_en) begin
            state_d = FLUSH;
          end else begin
            state_d = WAIT_ACK;
            tmr_clr = 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        // A good ACK takes priority over a simultaneous timer expiry.
        if (i_ack_valid && i_ack_good) begin
          state_d = FLUSH;
        end else if ((i_ack_valid && !i_ack_good) || tmr_expire) begin
          if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = RETRANS;
          end else begin
            fail_d  = 1'b1;
            state_d = FLUSH;
          end
        end
      end
      RETRANS: begin
        if (i_frame_done) begin
          state_d = WAIT_ACK;
          tmr_clr = 1'b1;
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      retry_q <= '0;
      fail_q  <= 1'b0;
      hold_q  <= 1'b0;
      sel_q   <= 1'b0;
      req_q   <= 1'b0;
      cmpl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      fail_q  <= fail_d;
      hold_q  <= (state_d == WAIT_ACK) || (state_d == RETRANS);
      sel_q   <= (state_d == RETRANS);
      req_q   <= (state_d == RETRANS);
      cmpl_q  <= (state_d == FLUSH);
    end
  end

  assign o_mapper_hold   = hold_q;
  assign o_sel_line_fifo = sel_q;
  assign o_retrans_req   = req_q;
  assign o_send_complete = cmpl_q;
  assign o_fail          = fail_q;
  assign o_retry_cnt     = retry_q;

`ifdef ARQ_SCHED_STATS_EN
  logic [15:0] tx_frames_q, retrans_total_q;
  logic [7:0]  fail_total_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tx_frames_q     <= '0;
      retrans_total_q <= '0;
      fail_total_q    <= '0;
    end else begin
      if ((state_d == FLUSH) && (tx_frames_q != '1)) begin
        tx_frames_q <= tx_frames_q + 1'b1;
      end
      if ((state_q != RETRANS) && (state_d == RETRANS) && (retrans_total_q != '1)) begin
        retrans_total_q <= retrans_total_q + 1'b1;
      end
      if (fail_d && !fail_q && (fail_total_q != '1)) begin
        fail_total_q <= fail_total_q + 1'b1;
      end
    end
  end

  assign o_tx_frames     = tx_frames_q;
  assign o_retrans_total = retrans_total_q;
  assign o_fail_total    = fail_total_q;
`endif

endmodule

// File: tb/tb_arq_scheduler.sv
// Directed self-checking bench for arq_scheduler (TIMEOUT_CYC=100, MAX_RETRY=3).
module tb_arq_scheduler;

  localparam int unsigned TO = 100;
  localparam int unsigned MR = 3;
  localparam int unsigned TW = 18;
  localparam int unsigned RW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, arq_en = 1'b1, fas = 1'b0, done = 1'b0, ack_v = 1'b0, ack_g = 1'b0;
  logic hold, sel, req, cmpl, fail;
  logic [RW-1:0] rcnt;
`ifdef ARQ_SCHED_STATS_EN
  logic [15:0] txf, rtt;
  logic [7:0]  flt;
`endif

  // {mapper_hold, sel_line_fifo, retrans_req, send_complete, fail}
  logic [4:0] outs;
  assign outs = {hold, sel, req, cmpl, fail};

  int tests = 0;
  int fails = 0;

  arq_scheduler #(
    .TIMEOUT_CYC (TO),
    .MAX_RETRY   (MR),
    .TMR_W       (TW),
    .RTY_W       (RW)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_arq_en        (arq_en),
    .i_frame_fas     (fas),
    .i_frame_done    (done),
    .i_ack_valid     (ack_v),
    .i_ack_good      (ack_g),
    .o_mapper_hold   (hold),
    .o_sel_line_fifo (sel),
    .o_retrans_req   (req),
    .o_send_complete (cmpl),
    .o_fail          (fail),
    .o_retry_cnt     (rcnt)
`ifdef ARQ_SCHED_STATS_EN
    ,
    .o_tx_frames     (txf),
    .o_retrans_total (rtt),
    .o_fail_total    (flt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic n_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fas_pulse();
    fas = 1'b1; tick(); fas = 1'b0;
  endtask

  task automatic done_pulse();
    done = 1'b1; tick(); done = 1'b0;
  endtask

  task automatic ack_pulse(input logic good);
    ack_v = 1'b1; ack_g = good; tick(); ack_v = 1'b0; ack_g = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    n_ticks(2);
    tests++; if (outs !== 5'b00000) begin fails++; $display("FAIL reset_outs: got %b exp 00000", outs); end
    tests++; if (rcnt !== 2'd0) begin fails++; $display("FAIL reset_retry: got %0d exp 0", rcnt); end
    rst_n = 1'b1;
    tick();
    tests++; if (outs !== 5'b00000) begin fails++; $display("FAIL reset_release: got %b exp 00000", outs); end
  endtask

  task automatic test_good_ack();
    fas_pulse();
    tests++; if (outs !== 5'b00000) begin fails++; $display("FAIL good_send: got %b exp 00000", outs); end
    done_pulse();
    tests++; if (outs !== 5'b10000) begin fails++; $display("FAIL good_wait: got %b exp 10000", outs); end
    n_ticks(10);
    tests++; if (outs !== 5'b10000) begin fails++; $display("FAIL good_wait10: got %b exp 10000", outs); end
    ack_pulse(1'b1);
    tests++; if (outs !== 5'b00010) begin fails++; $display("FAIL good_flush: got %b exp 00010", outs); end
    tests++; if (rcnt !== 2'd0) begin fails++; $display("FAIL good_retry: got %0d exp 0", rcnt); end
    tick();
    tests++; if (outs !== 5'b00000) begin fails++; $display("FAIL good_pulse_len: got %b exp 00000", outs); end
  endtask

  task automatic test_nak();
    fas_pulse();
    done_pulse();
    arq_en = 1'b0;
    n_ticks(5);
    ack_pulse(1'b0);
    tests++; if (outs !== 5'b11100) begin fails++; $display("FAIL nak_retrans: got %b exp 11100", outs); end
    tests++; if (rcnt !== 2'd1) begin fails++; $display("FAIL nak_retry: got %0d exp 1", rcnt); end
    ack_pulse(1'b1);
    tests++; if (outs !== 5'b11100) begin fails++; $display("FAIL nak_ack_ignored: got %b exp 11100", outs); end
    fas_pulse();
    tests++; if (outs !== 5'b11100) begin fails++; $display("FAIL nak_fas_ignored: got %b exp 11100", outs); end
    done_pulse();
    tests++; if (outs !== 5'b10000) begin fails++; $display("FAIL nak_rewait: got %b exp 10000", outs); end
    ack_pulse(1'b1);
    tests++; if (outs !== 5'b00010) begin fails++; $display("FAIL nak_flush: got %b exp 00010", outs); end
    tests++; if (rcnt !== 2'd1) begin fails++; $display("FAIL nak_retry_hold: got %0d exp 1", rcnt); end
    arq_en = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    fas_pulse();
    done_pulse();
    for (int a = 0; a <= 3; a++) begin
      n_ticks(TO - 1);
      tests++; if (outs !== 5'b10000) begin fails++; $display("FAIL to_wait%0d: got %b exp 10000", a, outs); end
      tick();
      if (a < 3) begin
        tests++; if (outs !== 5'b11100) begin fails++; $display("FAIL to_retrans%0d: got %b exp 11100", a, outs); end
        tests++; if (rcnt !== RW'(a + 1)) begin fails++; $display("FAIL to_retry%0d: got %0d exp %0d", a, rcnt, a + 1); end
        done_pulse();
      end else begin
        tests++; if (outs !== 5'b00011) begin fails++; $display("FAIL to_fail_flush: got %b exp 00011", outs); end
        tests++; if (rcnt !== 2'd3) begin fails++; $display("FAIL to_retry_max: got %0d exp 3", rcnt); end
      end
    end
    tick();
    tests++; if (outs !== 5'b00001) begin fails++; $display("FAIL to_fail_sticky: got %b exp 00001", outs); end
    fas_pulse();
    tests++; if (outs !== 5'b00000) begin fails++; $display("FAIL to_fail_clear: got %b exp 00000", outs); end
    tests++; if (rcnt !== 2'd0) begin fails++; $display("FAIL to_retry_clear: got %0d exp 0", rcnt); end
    done_pulse();
    ack_pulse(1'b1);
    tick();
  endtask

  task automatic test_passthrough();
    arq_en = 1'b0;
    fas_pulse();
    tests++; if (outs !== 5'b00000) begin fails++; $display("FAIL pt_send: got %b exp 00000", outs); end
    done_pulse();
    tests++; if (outs !== 5'b00010) begin fails++; $display("FAIL pt_flush: got %b exp 00010", outs); end
    tick();
    tests++; if (outs !== 5'b00000) begin fails++; $display("FAIL pt_idle: got %b exp 00000", outs); end
    arq_en = 1'b1;
  endtask

  task automatic test_ack_timeout_race();
    fas_pulse();
    done_pulse();
    n_ticks(TO - 1);
    ack_pulse(1'b1);
    tests++; if (outs !== 5'b00010) begin fails++; $display("FAIL race_flush: got %b exp 00010", outs); end
    tests++; if (rcnt !== 2'd0) begin fails++; $display("FAIL race_retry: got %0d exp 0", rcnt); end
    tick();
  endtask

  task automatic test_reset_retrans();
    fas_pulse();
    done_pulse();
    ack_pulse(1'b0);
    tests++; if (outs !== 5'b11100) begin fails++; $display("FAIL rr_retrans: got %b exp 11100", outs); end
    rst_n = 1'b0;
    tick();
    tests++; if (outs !== 5'b00000) begin fails++; $display("FAIL rr_reset: got %b exp 00000", outs); end
    tests++; if (rcnt !== 2'd0) begin fails++; $display("FAIL rr_retry: got %0d exp 0", rcnt); end
    rst_n = 1'b1;
    tick();
    tests++; if (outs !== 5'b00000) begin fails++; $display("FAIL rr_no_flush: got %b exp 00000", outs); end
  endtask

`ifdef ARQ_SCHED_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    fas_pulse();
    done_pulse();
    ack_pulse(1'b0);
    done_pulse();
    ack_pulse(1'b0);
    done_pulse();
    ack_pulse(1'b1);
    tests++; if (txf !== 16'd1) begin fails++; $display("FAIL st_tx: got %0d exp 1", txf); end
    tests++; if (rtt !== 16'd2) begin fails++; $display("FAIL st_retrans: got %0d exp 2", rtt); end
    tests++; if (flt !== 8'd0) begin fails++; $display("FAIL st_fail: got %0d exp 0", flt); end
    tests++; if (rcnt !== 2'd2) begin fails++; $display("FAIL st_retry: got %0d exp 2", rcnt); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_good_ack();
    test_nak();
    test_timeout();
    test_passthrough();
    test_ack_timeout_race();
    test_reset_retrans();
`ifdef ARQ_SCHED_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
